serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer. Adds two WIDTH-bit operands one bit per clock through a single shared full-adder slice. The slice is two half_adder instances, with their carries combined by or_gate.
- Trades WIDTH cycles of latency for one adder slice.
- Serves as the low-area arithmetic path for Overture-style datapaths.
- Start/busy/done handshake; result held until overwritten.

Parameters:
WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
inStart  input  1  request to begin an addition; sampled on rising clk.
inA  input  WIDTH  operand A; sampled only on the accepting edge.
inB  input  WIDTH  operand B; sampled only on the accepting edge.
inCarryIn  input  1  carry-in; sampled only on the accepting edge.
outSum  output  WIDTH  registered result (A+B+cin)[WIDTH-1:0].
outCarry  output  1  registered carry-out of the MSB.
outBusy  output  1  high while in RUN.
outDone  output  1  one-cycle pulse; result valid and newly written.

Behaviour:
Reset:
- rst=1 forces state IDLE immediately (async), independent of clk.
- Clears the internal shift registers, carry flop and bit counter.
- outSum=0, outCarry=0, outBusy=0, outDone=0.

States:
- IDLE: outBusy=0, outDone=0.
  - inStart=1 at an edge: load shA=inA, shB=inB, c=inCarryIn, cnt=0; go to RUN.
  - Otherwise stay.
- RUN: outBusy=1, outDone=0. Each edge:
  - Full-adder slice on shA[0], shB[0], c. HA1(shA[0], shB[0]) gives s1/c1; HA2(s1, c) gives sum bit/c2; cout = c1 OR c2.
  - shS <= {sumbit, shS[WIDTH-1:1]}; shA, shB shift right by 1; c <= cout; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: also outSum <= final shS value (including this bit), outCarry <= cout; go to DONE.
  - inStart is ignored in RUN.
- DONE: outBusy=0, outDone=1 for exactly this one cycle.
  - inStart=1 at the edge: accepted exactly as from IDLE (back-to-back, no bubble); go to RUN.
  - Else go to IDLE.

Latency and hold rules:
- Accepting edge E0. outDone is high in the cycle following edge E0+WIDTH.
- Result is readable from that cycle on.
- outSum/outCarry change only on the RUN→DONE edge or on reset. They hold across IDLE and across a subsequent RUN.
- inA/inB/inCarryIn changes after the accepting edge have no effect on the operation in flight.

Arithmetic and sizing:
- Modulo 2^WIDTH; overflow is reported only via outCarry. No signed interpretation.
- cnt width = max(1, ceil(log2(WIDTH))).
- WIDTH=1: RUN lasts one edge, then DONE.

Reset mid-RUN:
- Operation is aborted and all outputs are cleared.
- No outDone pulse is produced for the aborted operation.

Test Plan:
- WIDTH=8; inA=0x35, inB=0x4A, cin=0, start pulsed at edge 0 -> outBusy=1 after edges 1..8 (high in cycles 1–8); outDone=1 only in cycle 9; outSum=0x7F, outCarry=0.
- inA=0xFF, inB=0x01, cin=0 -> outSum=0x00, outCarry=1. Then inA=0xFF, inB=0xFF, cin=1 -> outSum=0xFF, outCarry=1.
- inStart held high throughout, with operands changed every cycle during RUN -> only the first operands are used. A second operation starts on the DONE-cycle edge; its outDone follows exactly 9 cycles after the first.
- Assert rst asynchronously (between clock edges) at cycle 4 of RUN -> all outputs 0 immediately; no outDone. A fresh start of 0x10+0x20 -> 0x30, carry 0.
- In IDLE after a completed 0x35+0x4A: change inA/inB with inStart=0 for 20 cycles -> outSum stays 0x7F; outDone stays 0.
- WIDTH=1 build; inA=1, inB=1, cin=1 -> outDone in cycle 2; outSum=1, outCarry=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder slice (two half adders plus an OR) walks the operands LSB first.
// Accept edge E0, outDone pulses the cycle after edge E0+WIDTH; inStart is ignored while busy.
`timescale 1ns/1ps

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module or_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a | i_b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inStart,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inCarryIn,
  output logic [WIDTH-1:0] outSum,
  output logic             outCarry,
  output logic             outBusy,
  output logic             outDone
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [WIDTH-1:0] r_shs;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_s1;
  logic             w_c1;
  logic             w_sumbit;
  logic             w_c2;
  logic             w_cout;
  logic [WIDTH-1:0] w_shs_next;

  half_adder u_ha1 (.i_a(r_sha[0]), .i_b(r_shb[0]), .o_s(w_s1),     .o_c(w_c1));
  half_adder u_ha2 (.i_a(w_s1),     .i_b(r_c),      .o_s(w_sumbit), .o_c(w_c2));
  or_gate    u_or  (.i_a(w_c1),     .i_b(w_c2),     .o_y(w_cout));

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shs_next = w_sumbit;
    end else begin : g_wn
      assign w_shs_next = {w_sumbit, r_shs[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (inStart) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (inStart) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sha   <= '0;
      r_shb   <= '0;
      r_shs   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_sha <= inA;
      r_shb <= inB;
      r_c   <= inCarryIn;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_sha <= r_sha >> 1;
      r_shb <= r_shb >> 1;
      r_shs <= w_shs_next;
      r_c   <= w_cout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum   <= w_shs_next;
        r_carry <= w_cout;
      end
    end
  end

  assign outSum   = r_sum;
  assign outCarry = r_carry;
  assign outBusy  = (r_state == S_RUN);
  assign outDone  = (r_state == S_DONE);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance and a 1-bit instance sharing clock and reset.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic [7:0] sum8;
  logic       carry8, busy8, done8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic [0:0] sum1;
  logic       carry1, busy1, done1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .inStart(start8), .inA(a8), .inB(b8), .inCarryIn(cin8),
    .outSum(sum8), .outCarry(carry8), .outBusy(busy8), .outDone(done8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .inStart(start1), .inA(a1), .inB(b1), .inCarryIn(cin1),
    .outSum(sum1), .outCarry(carry1), .outBusy(busy1), .outDone(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start at the next edge, then watch busy for cycles 1..8 and done in cycle 9.
  // With scramble set, operands change every cycle after acceptance.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input bit scramble);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check({tag, "_busy"}, {30'd0, busy8, done8}, 32'h2);
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
    end
    check({tag, "_done"}, {30'd0, busy8, done8}, 32'h1);
    check({tag, "_sum"},  32'(sum8),   32'(es));
    check({tag, "_cout"}, 32'(carry8), 32'(ec));
  endtask

  initial begin
    #1;
    check("rst_async_outs", {22'd0, sum8, carry8, busy8, done8}, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_held_outs", {22'd0, sum8, carry8, busy8, done8}, 32'h0);
    rst = 1'b0;

    op8("t1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    op8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // inStart held high: first 0x12+0x34, second 0x80+0x80+1 accepted on the DONE edge.
    @(negedge clk);
    check("t3_idle", {30'd0, busy8, done8}, 32'h0);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      check("t3_run1_busy", {30'd0, busy8, done8}, 32'h2);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    check("t3_done1", {23'd0, sum8, carry8, done8}, {23'd0, 8'h46, 1'b0, 1'b1});
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      check("t3_run2_busy", {30'd0, busy8, done8}, 32'h2);
      check("t3_run2_hold", 32'(sum8), 32'h46);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    check("t3_done2", {23'd0, sum8, carry8, done8}, {23'd0, 8'h01, 1'b1, 1'b1});
    start8 = 1'b0;
    @(negedge clk);
    check("t3_back_idle", {30'd0, busy8, done8}, 32'h0);

    // Reset asserted between edges in cycle 4 of a run.
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_pre_busy", 32'(busy8), 32'h1);
    #2 rst = 1'b1;
    #1 check("t4_rst_outs", {22'd0, sum8, carry8, busy8, done8}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
        if (done8 || busy8) pulses++;
        @(negedge clk);
      end
      check("t4_no_done", 32'(pulses), 32'h0);
    end
    op8("t4_fresh", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Result holds in IDLE while operands wander.
    op8("t5", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      check("t5_hold", {22'd0, sum8, carry8, busy8, done8}, {22'd0, 8'h7F, 3'b000});
    end

    // WIDTH=1: 1+1+1 = 0b11.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("w1_busy", {30'd0, busy1, done1}, 32'h2);
    @(negedge clk);
    check("w1_done", {29'd0, sum1, carry1, done1}, 32'h7);
    @(negedge clk);
    check("w1_idle", {29'd0, sum1, carry1, done1}, 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
